// File: rtl/video_pattern_gen.sv
// ---------------------------------------------------------------------------
// video_pattern_gen
//
// Test-pattern pixel source for the DVI output path. After reset it waits
// IDLE_CYCLES clocks, then streams an endless H_ACTIVE x V_ACTIVE raster of
// {R,G,B} pixels over a valid/ready handshake. Four patterns are available:
// solid, colour bars, checkerboard and a gradient that scrolls one step per
// frame. Mode/SolidColor are sampled only at frame boundaries.
//
// Ports:
//   Clock       in   sole clock, posedge
//   Reset       in   synchronous, active-high
//   Mode        in   0 solid, 1 bars, 2 checker, 3 gradient
//   SolidColor  in   {R,G,B} used by the solid pattern
//   VideoReady  in   sink accepts the presented pixel
//   VideoValid  out  Video carries a pixel
//   Video       out  {R,G,B}, R in the MSBs, 0 while VideoValid is low
//   VideoSOF    out  first pixel of frame   (PATGEN_FLAGS_EN only)
//   VideoEOL    out  last pixel of a line   (PATGEN_FLAGS_EN only)
//
// Build option: define PATGEN_FLAGS_EN to add the VideoSOF/VideoEOL ports.
//
// All outputs are decoded from registered state only, so VideoReady has no
// combinational path to any output and a stalled pixel holds naturally.
// ---------------------------------------------------------------------------
module video_pattern_gen #(
    parameter int H_ACTIVE    = 1024,
    parameter int V_ACTIVE    = 768,
    parameter int IDLE_CYCLES = 5000,
    parameter int COLOR_W     = 8,
    parameter int CHECK_LOG2  = 5
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [1:0]             Mode,
    input  logic [3*COLOR_W-1:0]   SolidColor,
    input  logic                   VideoReady,
    output logic                   VideoValid,
    output logic [3*COLOR_W-1:0]   Video
`ifdef PATGEN_FLAGS_EN
    ,
    output logic                   VideoSOF,
    output logic                   VideoEOL
`endif
);

    localparam int XW    = $clog2(H_ACTIVE);
    localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int IW    = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int PW    = 3 * COLOR_W;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [COLOR_W-1:0]   off_q, off_d;
    logic [1:0]           mode_q, mode_d;
    logic [PW-1:0]        color_q, color_d;
    // Bar position tracked incrementally so no divider by H_ACTIVE/8 is needed.
    logic [BW-1:0]        bar_cnt_q, bar_cnt_d;
    logic [2:0]           bar_idx_q, bar_idx_d;

    logic last_x, last_y;

    assign last_x = (x_q == XW'(H_ACTIVE - 1));
    assign last_y = (y_q == YW'(V_ACTIVE - 1));

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        off_d      = off_q;
        mode_d     = mode_q;
        color_d    = color_q;
        bar_cnt_d  = bar_cnt_q;
        bar_idx_d  = bar_idx_q;
        case (state_q)
            S_IDLE: begin
                idle_cnt_d = idle_cnt_q + 1'b1;
                if (idle_cnt_q == IW'(IDLE_CYCLES - 1)) begin
                    state_d = S_RUN;
                    mode_d  = Mode;
                    color_d = SolidColor;
                end
            end
            S_RUN: begin
                if (VideoReady) begin
                    if (last_x) begin
                        x_d       = '0;
                        bar_cnt_d = '0;
                        bar_idx_d = '0;
                        if (last_y) begin
                            // Frame boundary: scroll gradient, resample mode.
                            y_d     = '0;
                            off_d   = off_q + 1'b1;
                            mode_d  = Mode;
                            color_d = SolidColor;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                        if (bar_cnt_q == BW'(BAR_W - 1)) begin
                            bar_cnt_d = '0;
                            bar_idx_d = bar_idx_q + 1'b1;
                        end else begin
                            bar_cnt_d = bar_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            idle_cnt_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            off_q      <= '0;
            mode_q     <= 2'd0;
            color_q    <= '0;
            bar_cnt_q  <= '0;
            bar_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            off_q      <= off_d;
            mode_q     <= mode_d;
            color_q    <= color_d;
            bar_cnt_q  <= bar_cnt_d;
            bar_idx_q  <= bar_idx_d;
        end
    end

    // Checker square parity; a square wider than the raster never toggles.
    logic x_bit, y_bit;
    if (CHECK_LOG2 < XW) begin : g_xbit
        assign x_bit = x_q[CHECK_LOG2];
    end else begin : g_xbit0
        assign x_bit = 1'b0;
    end
    if (CHECK_LOG2 < YW) begin : g_ybit
        assign y_bit = y_q[CHECK_LOG2];
    end else begin : g_ybit0
        assign y_bit = 1'b0;
    end

    logic [COLOR_W-1:0] grad_r, grad_g, grad_b;
    logic [PW-1:0]      pix;

    assign grad_r = COLOR_W'(x_q) + off_q;
    assign grad_g = COLOR_W'(y_q) + off_q;
    assign grad_b = COLOR_W'(x_q) + COLOR_W'(y_q);

    always_comb begin
        pix = '0;
        case (mode_q)
            2'd0: pix = color_q;
            // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
            2'd1: pix = {{COLOR_W{~bar_idx_q[1]}},
                         {COLOR_W{~bar_idx_q[2]}},
                         {COLOR_W{~bar_idx_q[0]}}};
            2'd2: pix = (x_bit ^ y_bit) ? '0 : '1;
            default: pix = {grad_r, grad_g, grad_b};
        endcase
    end

    assign VideoValid = (state_q == S_RUN);
    assign Video      = VideoValid ? pix : '0;

`ifdef PATGEN_FLAGS_EN
    assign VideoSOF = VideoValid & (x_q == '0) & (y_q == '0);
    assign VideoEOL = VideoValid & last_x;
`endif

endmodule

// File: tb/tb_video_pattern_gen.sv
module tb_video_pattern_gen;

    localparam int H    = 64;
    localparam int V    = 4;
    localparam int IDLE = 16;
    localparam int CW   = 8;
    localparam int CL   = 5;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] col = 24'h0;
    logic        vld;
    logic [23:0] vid;
`ifdef PATGEN_FLAGS_EN
    logic        sof, eol;
`endif

    always #5 clk = ~clk;

    video_pattern_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .IDLE_CYCLES(IDLE), .COLOR_W(CW), .CHECK_LOG2(CL)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .Mode(mode),
        .SolidColor(col),
        .VideoReady(rdy),
        .VideoValid(vld),
        .Video(vid)
`ifdef PATGEN_FLAGS_EN
        ,
        .VideoSOF(sof),
        .VideoEOL(eol)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: linear pixel index within the frame plus frame count.
    bit          m_valid = 1'b0;
    int          m_edges = 0;
    int          m_p = 0;
    int          m_frame = 0;
    int          m_mode = 0;
    logic [23:0] m_col = 24'h0;

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (frame %0d pix %0d)", tag, got, exp, m_frame, m_p);
        end
    endtask

    function automatic logic [23:0] bar_rgb(input int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] pat(input int md, input logic [23:0] c,
                                        input int x, input int y, input int off);
        logic [7:0] r, g, b;
        r = 8'((x + off) % 256);
        g = 8'((y + off) % 256);
        b = 8'((x + y) % 256);
        case (md)
            0: return c;
            1: return bar_rgb(x / (H / 8));
            2: return ((((x >> CL) ^ (y >> CL)) & 1) == 0) ? 24'hFFFFFF : 24'h000000;
            default: return {r, g, b};
        endcase
    endfunction

    // One clock: drive inputs, advance the model across the edge, check at +1.
    task automatic cyc(input bit r, input bit rd, input logic [1:0] md, input logic [23:0] c);
        int x, y;
        logic [23:0] exp_vid;
        rst = r; rdy = rd; mode = md; col = c;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0; m_edges = 0; m_p = 0; m_frame = 0; m_mode = 0; m_col = 24'h0;
        end else if (!m_valid) begin
            m_edges++;
            if (m_edges == IDLE) begin
                m_valid = 1'b1; m_mode = int'(md); m_col = c;
            end
        end else if (rd) begin
            m_p++;
            if (m_p == NPIX) begin
                m_p = 0; m_frame++; m_mode = int'(md); m_col = c;
            end
        end
        #1;
        x = m_p % H;
        y = m_p / H;
        exp_vid = m_valid ? pat(m_mode, m_col, x, y, m_frame % 256) : 24'h0;
        chk("valid", 24'(vld), 24'(m_valid));
        chk("video", vid, exp_vid);
`ifdef PATGEN_FLAGS_EN
        chk("sof", 24'(sof), 24'(m_valid && m_p == 0));
        chk("eol", 24'(eol), 24'(m_valid && x == H - 1));
`endif
        if (m_valid) begin
            if (m_mode == 1 && y == 0) begin
                if (x == 7)  chk("bar_x7",  vid, 24'hFFFFFF);
                if (x == 8)  chk("bar_x8",  vid, 24'hFFFF00);
                if (x == 55) chk("bar_x55", vid, 24'h0000FF);
                if (x == 56) chk("bar_x56", vid, 24'h000000);
            end
            if (m_mode == 2 && m_p == 0)  chk("chk_0_0",  vid, 24'hFFFFFF);
            if (m_mode == 2 && m_p == 32) chk("chk_32_0", vid, 24'h000000);
            if (m_mode == 3 && m_frame == 0 && m_p == 0)         chk("grad_f0_0_0", vid, 24'h000000);
            if (m_mode == 3 && m_frame == 0 && m_p == 2 * H + 5) chk("grad_f0_5_2", vid, 24'h050207);
            if (m_mode == 3 && m_frame == 1 && m_p == 0) begin
                chk("grad_f1_0_0", vid, 24'h010100);
`ifdef PATGEN_FLAGS_EN
                chk("grad_f1_sof", 24'(sof), 24'h1);
`endif
            end
        end
    endtask

    initial begin
        int first;
        int k;
        // Reset, then measure the idle period with Ready high.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 2'd1, 24'h0);
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, 1'b1, 2'd1, 24'h0);
            if (vld && first == 0) first = i;
        end
        chk("idle_len", 24'(first), 24'(IDLE));

        // Bars for frames 0 and 1.
        for (int i = 0; i < 3000 && m_frame < 1; i++) cyc(1'b0, 1'b1, 2'd1, 24'h0);

        // Solid 123456 with Ready pattern 1,0,0,1 (frame 2 solid).
        k = 0;
        for (int i = 0; i < 6000 && m_frame < 3; i++) begin
            cyc(1'b0, (k % 4 == 0) || (k % 4 == 3), 2'd0, 24'h123456);
            k++;
        end

        // Switch to checker at pixel 100 of frame 3; frame 3 stays solid.
        for (int i = 0; i < 6000 && m_frame < 5; i++)
            cyc(1'b0, $urandom_range(0, 3) != 0,
                (m_frame >= 4 || m_p >= 100) ? 2'd2 : 2'd0, 24'h123456);

        // Gradient, then reset at pixel (10,2) of a gradient frame.
        for (int i = 0; i < 6000 && m_frame < 6; i++)
            cyc(1'b0, $urandom_range(0, 3) != 0, 2'd3, 24'h0);
        for (int i = 0; i < 6000 && !(m_frame == 6 && m_p == 2 * H + 10); i++)
            cyc(1'b0, $urandom_range(0, 3) != 0, 2'd3, 24'h0);
        cyc(1'b1, 1'b1, 2'd3, 24'h0);
        for (int i = 0; i < 3000 && m_frame < 2; i++) cyc(1'b0, 1'b1, 2'd3, 24'h0);

        // Fully random traffic with occasional resets.
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0,
                2'($urandom_range(0, 3)), 24'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
